eth_frame_builder: RTL and testbench
====================================

# eth_frame_builder

Upstream stage of the Ethernet send/FCS controller. Assembles one Ethernet/IPv4/UDP frame in the shared frame RAM: a fixed header, an optional frame sequence number, and camera pixel bytes from the pixel FIFO. It then starts the send/FCS controller by releasing its reset, waits for the frame-finished indication, and enforces an inter-frame gap before building the next frame.

## Interface
Parameters:
- ETH_FRAME_SIZE, 1400: total RAM frame bytes, including 4 FCS bytes written by the send/FCS controller.
- HDR_LEN, 42: header bytes (14 Ethernet + 20 IPv4 + 8 UDP).
- IFG_CYCLES, 96: idle clk cycles after a frame completes.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- pix_data  in  8  pixel byte from the camera FIFO.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  builder accepts a byte this cycle.
- ram_addr  out  11  frame RAM write address.
- ram_data_in  out  8  frame RAM write data.
- ram_wr_en  out  1  frame RAM write strobe.
- tx_reset  out  1  drives the send/FCS controller reset: 1 = hold idle, 0 = transmit.
- tx_finish  in  1  frame-finished level from the send/FCS controller (eth_clk domain).
- busy  out  1  high in every state except IDLE.
- seq_num  out  16  sequence number of the next frame.

## Operation
- States: IDLE, HEADER, PAYLOAD, LAUNCH, WAIT_TX, GAP.
- **IDLE:** leave when pix_valid = 1.
- **HEADER:** write one header byte per cycle from the package ROM to addresses 0..HDR_LEN-1. With sequence numbers enabled, also write seq_num big-endian to HDR_LEN and HDR_LEN+1.
- **PAYLOAD:**
  - pix_ready = 1; write one byte on each cycle where pix_valid && pix_ready.
  - The address increments per accepted byte through ETH_FRAME_SIZE-5 (1395 at default).
  - If pix_valid = 0, nothing is written and the address holds.
- **LAUNCH:** one cycle; tx_reset goes to 0.
- **WAIT_TX:**
  - tx_reset stays 0.
  - tx_finish passes through a 2-flop synchronizer; a detected rising edge sets tx_reset = 1, increments seq_num, and moves to GAP.
- **GAP:** count IFG_CYCLES cycles, then return to IDLE.
- seq_num wraps 0xFFFF -> 0x0000.
- pix_ready = 0 outside PAYLOAD. ram_wr_en = 0 outside HEADER/PAYLOAD.
- **Reset mid-operation:**
  - Next edge returns to IDLE with all outputs at reset values.
  - tx_reset = 1 aborts any transmission in progress.
  - seq_num clears to 0.

## Timing
- **Reset values:** ram_wr_en 0, ram_addr 0, ram_data_in 0, pix_ready 0, tx_reset 1, busy 0, seq_num 0.
- **All outputs registered.** RAM writes appear on ram_* one cycle after the state/acceptance decision.
- **Header latency:** HDR_LEN (+2 with sequence numbers) cycles after leaving IDLE.
- **Launch timing:** tx_reset falls the cycle after the last payload write is issued.
- **Finish-to-release latency:** from a tx_finish edge to tx_reset = 1 is 3 clk cycles (2 synchronizer flops + 1 edge register).
- **Back-to-back frames:** the next header write starts no earlier than IFG_CYCLES+1 cycles after tx_reset rises.

## Configuration
- FRAME_SEQ_EN defined:
  - Sequence bytes are written at HDR_LEN and HDR_LEN+1.
  - Payload starts at HDR_LEN+2, giving ETH_FRAME_SIZE-HDR_LEN-6 pixel bytes.
- FRAME_SEQ_EN undefined:
  - No sequence bytes; payload starts at HDR_LEN.
  - seq_num is tied to 0 and the counter is removed.

## Structure
- **Package eth_frame_pkg:**
  - State enum.
  - HDR_LEN default.
  - Header byte ROM constant: broadcast destination MAC, source MAC, EtherType 0x0800, fixed IPv4 header with precomputed checksum, fixed UDP ports, UDP checksum 0.
- **Sub-module sync_rise:** 2-flop synchronizer plus rising-edge detector, used for tx_finish.

## Test plan
- **Header contents:** reset, then pix_valid = 1 → addresses 0..41 receive the package ROM bytes; address 12 = 0x08, address 13 = 0x00; tx_reset stays 1 until the payload is complete.
- **Sequence bytes and payload (FRAME_SEQ_EN on):** stream incrementing bytes starting at 0x00 →
  - address 42 = 0x00 and 43 = 0x00 (seq);
  - address 44 = first pixel;
  - last write at address 1395;
  - tx_reset = 0 the following cycle.
- **Stall:** pix_valid low for 10 cycles mid-payload → no ram_wr_en, ram_addr holds, no bytes lost.
- **Finish and next frame:** tx_finish rises →
  - tx_reset = 1 three cycles later;
  - seq_num = 1;
  - no RAM write for 96 cycles;
  - next frame writes 0x00, 0x01 at addresses 42/43.
- **Reset mid-payload:** reset asserted during PAYLOAD → next cycle all outputs at reset values, state IDLE, seq_num 0.
- **FRAME_SEQ_EN off:** first pixel written at address 42; seq_num constant 0.

Source files
------------

// File: rtl/eth_frame_pkg.sv
// Shared types and constants for the Ethernet frame builder.
// Latency: none (package only).
// Backpressure: n/a.
package eth_frame_pkg;

    // Number of fixed header bytes: 14 Ethernet + 20 IPv4 + 8 UDP.
    localparam int HDR_LEN_DEFAULT = 42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_LAUNCH,
        ST_WAIT_TX,
        ST_GAP
    } state_t;

    // Fixed header for a 1400-byte RAM frame: IPv4 total length 1382 (0x0566),
    // UDP length 1362 (0x0552). The IPv4 checksum 0xB22B is precomputed for
    // exactly these fields, so any field change needs a new checksum.
    localparam logic [7:0] HDR_ROM [HDR_LEN_DEFAULT] = '{
        // Ethernet: broadcast dst, locally administered src, EtherType IPv4
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
        8'h08, 8'h00,
        // IPv4: ver/IHL, TOS, total length, ID, DF, TTL 64, UDP, checksum
        8'h45, 8'h00, 8'h05, 8'h66, 8'h00, 8'h00, 8'h40, 8'h00,
        8'h40, 8'h11, 8'hB2, 8'h2B,
        // IPv4: src 192.168.1.10, dst 192.168.1.1
        8'hC0, 8'hA8, 8'h01, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'h01,
        // UDP: ports 8080 -> 8080, length, checksum unused
        8'h1F, 8'h90, 8'h1F, 8'h90, 8'h05, 8'h52, 8'h00, 8'h00
    };

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer with rising-edge detect for a level from another clock.
// Latency: rise_o asserts 2 clk edges after d_i rises; the edge register drops it one edge later.
// Backpressure: none; rise_o is a single-cycle pulse.
module sync_rise (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resynchronize the level, then keep one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/eth_frame_builder.sv
// Builds one Ethernet/IPv4/UDP frame in frame RAM (header, optional FRAME_SEQ_EN seq number, pixels), then launches TX.
// Latency: RAM writes are registered one cycle after the decision; tx_reset rises 3 cycles after a tx_finish edge.
// Backpressure: pix_ready only in PAYLOAD; a low pix_valid stalls the payload without losing bytes.
module eth_frame_builder
    import eth_frame_pkg::*;
#(
    parameter int ETH_FRAME_SIZE = 1400,
    parameter int HDR_LEN        = HDR_LEN_DEFAULT,
    parameter int IFG_CYCLES     = 96
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_data_in,
    output logic        ram_wr_en,
    output logic        tx_reset,
    input  logic        tx_finish,
    output logic        busy,
    output logic [15:0] seq_num
);

`ifdef FRAME_SEQ_EN
    localparam int SEQ_BYTES = 2;
`else
    localparam int SEQ_BYTES = 0;
`endif

    // Last header index, first/last payload address (last 4 bytes hold the FCS)
    localparam logic [5:0]  HDR_LAST  = 6'(HDR_LEN + SEQ_BYTES - 1);
    localparam logic [10:0] PAY_FIRST = 11'(HDR_LEN + SEQ_BYTES);
    localparam logic [10:0] PAY_LAST  = 11'(ETH_FRAME_SIZE - 5);
    localparam logic [15:0] GAP_LAST  = 16'(IFG_CYCLES - 1);

    state_t      state_q;
    logic [5:0]  hdr_idx_q;
    logic [10:0] pay_addr_q;
    logic [15:0] gap_cnt_q;
    logic [10:0] ram_addr_q;
    logic [7:0]  ram_data_q;
    logic        ram_wr_en_q;
    logic        pix_ready_q;
    logic        tx_reset_q;
    logic        busy_q;
    logic [7:0]  hdr_dat_d;
    logic        fin_rise;

    sync_rise u_fin_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (tx_finish),
        .rise_o (fin_rise)
    );

`ifdef FRAME_SEQ_EN
    logic [15:0] seq_q;

    // Header byte for the current index: ROM first, then big-endian sequence number
    always_comb begin
        hdr_dat_d = 8'h00;
        if (int'(hdr_idx_q) < HDR_LEN) begin
            hdr_dat_d = HDR_ROM[hdr_idx_q];
        end else if (int'(hdr_idx_q) == HDR_LEN) begin
            hdr_dat_d = seq_q[15:8];
        end else begin
            hdr_dat_d = seq_q[7:0];
        end
    end

    // Frame counter advances when the send controller reports a finished frame
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q <= 16'h0000;
        end else if (state_q == ST_WAIT_TX && fin_rise) begin
            seq_q <= seq_q + 16'h0001;
        end
    end

    assign seq_num = seq_q;
`else
    // Header byte for the current index: ROM only
    always_comb begin
        hdr_dat_d = 8'h00;
        if (int'(hdr_idx_q) < HDR_LEN) begin
            hdr_dat_d = HDR_ROM[hdr_idx_q];
        end
    end

    assign seq_num = 16'h0000;
`endif

    // Frame sequencing FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hdr_idx_q   <= 6'd0;
            pay_addr_q  <= 11'd0;
            gap_cnt_q   <= 16'd0;
            ram_addr_q  <= 11'd0;
            ram_data_q  <= 8'h00;
            ram_wr_en_q <= 1'b0;
            pix_ready_q <= 1'b0;
            tx_reset_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            ram_wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pix_valid) begin
                        state_q   <= ST_HEADER;
                        hdr_idx_q <= 6'd0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    ram_wr_en_q <= 1'b1;
                    ram_addr_q  <= 11'(hdr_idx_q);
                    ram_data_q  <= hdr_dat_d;
                    hdr_idx_q   <= hdr_idx_q + 6'd1;
                    if (hdr_idx_q == HDR_LAST) begin
                        state_q     <= ST_PAYLOAD;
                        pix_ready_q <= 1'b1;
                        pay_addr_q  <= PAY_FIRST;
                    end
                end
                ST_PAYLOAD: begin
                    // Address only advances on an accepted byte, so stalls hold it
                    if (pix_valid && pix_ready_q) begin
                        ram_wr_en_q <= 1'b1;
                        ram_addr_q  <= pay_addr_q;
                        ram_data_q  <= pix_data;
                        pay_addr_q  <= pay_addr_q + 11'd1;
                        if (pay_addr_q == PAY_LAST) begin
                            pix_ready_q <= 1'b0;
                            state_q     <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    tx_reset_q <= 1'b0;
                    state_q    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (fin_rise) begin
                        tx_reset_q <= 1'b1;
                        gap_cnt_q  <= 16'd0;
                        state_q    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pix_ready   = pix_ready_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data_in = ram_data_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign tx_reset    = tx_reset_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_eth_frame_builder.sv
// Directed bench for eth_frame_builder: header, payload, stall, finish/gap, reset.
// Frame RAM is modelled by capturing every ram_wr_en write.
// Expectations follow FRAME_SEQ_EN the same way the design build does.
`timescale 1ns/1ps
module tb_eth_frame_builder;

    localparam int HDR = 42;
`ifdef FRAME_SEQ_EN
    localparam bit SEQ_ON    = 1'b1;
    localparam int PAY_FIRST = 44;
`else
    localparam bit SEQ_ON    = 1'b0;
    localparam int PAY_FIRST = 42;
`endif
    localparam int PAY_LAST  = 1395;
    localparam int PAY_BYTES = PAY_LAST - PAY_FIRST + 1;
    localparam int IFG       = 96;
    localparam logic [10:0] PAY_LAST_A = 11'(PAY_LAST);

    localparam logic [7:0] EXP_HDR [HDR] = '{
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
        8'h08, 8'h00,
        8'h45, 8'h00, 8'h05, 8'h66, 8'h00, 8'h00, 8'h40, 8'h00,
        8'h40, 8'h11, 8'hB2, 8'h2B,
        8'hC0, 8'hA8, 8'h01, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'h01,
        8'h1F, 8'h90, 8'h1F, 8'h90, 8'h05, 8'h52, 8'h00, 8'h00
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pix_data = 8'h00;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [10:0] ram_addr;
    logic [7:0]  ram_data_in;
    logic        ram_wr_en;
    logic        tx_reset;
    logic        tx_finish = 1'b0;
    logic        busy;
    logic [15:0] seq_num;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:2047];
    int         wr_count = 0;

    eth_frame_builder dut (
        .clk         (clk),
        .reset       (reset),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .ram_addr    (ram_addr),
        .ram_data_in (ram_data_in),
        .ram_wr_en   (ram_wr_en),
        .tx_reset    (tx_reset),
        .tx_finish   (tx_finish),
        .busy        (busy),
        .seq_num     (seq_num)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_en === 1'b1) begin
            mem[ram_addr] <= ram_data_in;
            wr_count      <= wr_count + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stream incrementing pixels until the write to the last payload address shows up
    task automatic stream_frame(input logic [7:0] start, input bit do_stall,
                                output int accepted, output bit done,
                                output int early_low, output int stall_bad);
        logic [7:0]  pix;
        logic [10:0] held;
        bit          acc;
        pix       = start;
        accepted  = 0;
        done      = 1'b0;
        early_low = 0;
        stall_bad = 0;
        pix_data  = pix;
        pix_valid = 1'b1;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            acc = pix_valid && pix_ready;
            tick();
            if (acc) begin
                accepted++;
                pix      = pix + 8'd1;
                pix_data = pix;
            end
            if (tx_reset !== 1'b1) early_low++;
            if (ram_wr_en === 1'b1 && ram_addr === PAY_LAST_A) done = 1'b1;
            if (do_stall && acc && accepted == 100) begin
                held      = ram_addr;
                pix_valid = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    tick();
                    if (ram_wr_en !== 1'b0 || ram_addr !== held) stall_bad++;
                    if (tx_reset !== 1'b1) early_low++;
                end
                pix_valid = 1'b1;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL reset_ram_wr_en: got %b want 0", ram_wr_en); end
        checks++; if (ram_addr !== 11'd0) begin errors++; $display("FAIL reset_ram_addr: got %0d want 0", ram_addr); end
        checks++; if (ram_data_in !== 8'h00) begin errors++; $display("FAIL reset_ram_data_in: got %02h want 00", ram_data_in); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready: got %b want 0", pix_ready); end
        checks++; if (tx_reset !== 1'b1) begin errors++; $display("FAIL reset_tx_reset: got %b want 1", tx_reset); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (seq_num !== 16'h0000) begin errors++; $display("FAIL reset_seq_num: got %04h want 0000", seq_num); end
        reset = 1'b0;
        tick();
    endtask

    // First frame: header ROM, sequence bytes, payload with one 10-cycle stall, launch
    task automatic test_frame;
        int accepted, early_low, stall_bad, base, bad, first_bad;
        bit done;
        logic [7:0] want;
        base = wr_count;
        stream_frame(8'h00, 1'b1, accepted, done, early_low, stall_bad);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL frame1_last_write: write to %0d not seen within budget", PAY_LAST); end
        checks++; if (early_low !== 0) begin errors++; $display("FAIL frame1_tx_reset_early: tx_reset low %0d cycles before payload end, want 0", early_low); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold: %0d stall cycles wrote or moved address, want 0", stall_bad); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame1_busy: got %b want 1", busy); end
        tick();
        checks++; if (tx_reset !== 1'b0) begin errors++; $display("FAIL launch_tx_reset: got %b want 0 cycle after last write", tx_reset); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL launch_pix_ready: got %b want 0", pix_ready); end
        checks++; if (accepted !== PAY_BYTES) begin errors++; $display("FAIL frame1_accepted: got %0d want %0d", accepted, PAY_BYTES); end
        checks++; if (wr_count - base !== PAY_LAST + 1) begin errors++; $display("FAIL frame1_write_count: got %0d want %0d", wr_count - base, PAY_LAST + 1); end
        bad = 0; first_bad = -1;
        for (int i = 0; i < HDR; i++) begin
            if (mem[i] !== EXP_HDR[i]) begin bad++; if (first_bad < 0) first_bad = i; end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL header_rom: %0d bad bytes, first at %0d got %02h want %02h", bad, first_bad, mem[first_bad], EXP_HDR[first_bad]); end
        checks++; if (mem[12] !== 8'h08 || mem[13] !== 8'h00) begin errors++; $display("FAIL ethertype: got %02h%02h want 0800", mem[12], mem[13]); end
        if (SEQ_ON) begin
            checks++; if (mem[42] !== 8'h00 || mem[43] !== 8'h00) begin errors++; $display("FAIL frame1_seq_bytes: got %02h%02h want 0000", mem[42], mem[43]); end
        end
        checks++; if (mem[PAY_FIRST] !== 8'h00) begin errors++; $display("FAIL first_pixel: got %02h at %0d want 00", mem[PAY_FIRST], PAY_FIRST); end
        bad = 0; first_bad = -1;
        for (int i = 0; i < PAY_BYTES; i++) begin
            want = 8'(i);
            if (mem[PAY_FIRST + i] !== want) begin bad++; if (first_bad < 0) first_bad = i; end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL payload_bytes: %0d bad, first at %0d got %02h want %02h", bad, PAY_FIRST + first_bad, mem[PAY_FIRST + first_bad], 8'(first_bad)); end
    endtask

    // tx_finish edge, 3-cycle release, inter-frame gap, then the second frame
    task automatic test_finish_next;
        int accepted, early_low, stall_bad, gap_writes, gap_ready, n;
        bit done, seen;
        logic [7:0] want_last;
        repeat (5) tick();
        checks++; if (tx_reset !== 1'b0) begin errors++; $display("FAIL wait_tx_hold: got %b want 0", tx_reset); end
        tx_finish = 1'b1;
        tick(); tick();
        checks++; if (tx_reset !== 1'b0) begin errors++; $display("FAIL finish_early: tx_reset %b after 2 cycles want 0", tx_reset); end
        tick();
        checks++; if (tx_reset !== 1'b1) begin errors++; $display("FAIL finish_latency: tx_reset %b after 3 cycles want 1", tx_reset); end
        checks++; if (seq_num !== (SEQ_ON ? 16'h0001 : 16'h0000)) begin errors++; $display("FAIL seq_after_finish: got %04h want %04h", seq_num, SEQ_ON ? 16'h0001 : 16'h0000); end
        tx_finish = 1'b0;
        pix_data  = 8'h80;
        pix_valid = 1'b1;
        gap_writes = 0; gap_ready = 0;
        for (int i = 0; i < IFG; i++) begin
            tick();
            if (ram_wr_en !== 1'b0) gap_writes++;
            if (pix_ready !== 1'b0) gap_ready++;
        end
        checks++; if (gap_writes !== 0 || gap_ready !== 0) begin errors++; $display("FAIL gap_quiet: %0d writes %0d ready cycles in gap, want 0 0", gap_writes, gap_ready); end
        n = IFG; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(); n++;
            if (ram_wr_en === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen || n < IFG + 1) begin errors++; $display("FAIL next_header_start: first write seen=%0d at %0d cycles want >= %0d", seen, n, IFG + 1); end
        stream_frame(8'h80, 1'b0, accepted, done, early_low, stall_bad);
        tick();
        checks++; if (done !== 1'b1 || accepted !== PAY_BYTES) begin errors++; $display("FAIL frame2_payload: done=%0d accepted %0d want %0d", done, accepted, PAY_BYTES); end
        if (SEQ_ON) begin
            checks++; if (mem[42] !== 8'h00 || mem[43] !== 8'h01) begin errors++; $display("FAIL frame2_seq_bytes: got %02h%02h want 0001", mem[42], mem[43]); end
        end
        checks++; if (mem[PAY_FIRST] !== 8'h80) begin errors++; $display("FAIL frame2_first_pixel: got %02h want 80", mem[PAY_FIRST]); end
        want_last = 8'h80 + 8'(PAY_BYTES - 1);
        checks++; if (mem[PAY_LAST] !== want_last) begin errors++; $display("FAIL frame2_last_pixel: got %02h want %02h", mem[PAY_LAST], want_last); end
    endtask

    // Reset arriving in the middle of a payload returns everything to idle
    task automatic test_reset_mid_payload;
        bit seen;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pix_data  = 8'h55;
        pix_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (pix_ready === 1'b1) seen = 1'b1;
        end
        repeat (5) tick();
        checks++; if (!seen || ram_wr_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_payload_entry: ready_seen=%0d wr_en %b busy %b want 1 1 1", seen, ram_wr_en, busy); end
        reset = 1'b1;
        tick();
        checks++; if (ram_wr_en !== 1'b0 || ram_addr !== 11'd0 || ram_data_in !== 8'h00) begin errors++; $display("FAIL midrst_ram: wr_en %b addr %0d data %02h want 0 0 00", ram_wr_en, ram_addr, ram_data_in); end
        checks++; if (pix_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: pix_ready %b busy %b want 0 0", pix_ready, busy); end
        checks++; if (tx_reset !== 1'b1) begin errors++; $display("FAIL midrst_tx_reset: got %b want 1", tx_reset); end
        checks++; if (seq_num !== 16'h0000) begin errors++; $display("FAIL midrst_seq_num: got %04h want 0000", seq_num); end
        reset     = 1'b0;
        pix_valid = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || ram_wr_en !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b wr_en %b want 0 0", busy, ram_wr_en); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_finish_next();
        test_reset_mid_payload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
